violation_reset_ctrl: RTL

Central responder for the hardware-monitor violation signals (atomicity, key-access, DMA monitors) in the VRASED trusted hardware. It samples the per-monitor violation lines and turns any violation into a clean, fixed-length system reset pulse (PUC) for the MCU core. It then holds off further reaction until the core fetches the reset vector, and keeps a sticky cause mask and a saturating violation count for diagnostics. It sits between the monitor modules and the core's reset input.

---
 rtl/vrased_pkg.sv | 19 +
 rtl/vrased_cycle_timer.sv | 40 ++++
 rtl/violation_reset_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vrased_pkg.sv
// Shared definitions for the VRASED hardware monitors and the violation reset controller.
package vrased_pkg;

    // Controller states; 2-bit encoding shared with anything that observes the FSM.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD     = 2'd1,
        WAIT_VEC = 2'd2
    } vr_state_e;

    // PC of the reset handler: seeing it fetched proves the core has restarted.
    localparam logic [15:0] RESET_HANDLER = 16'hFFFE;

    // Larger of two integers, used to size counters that hold either of two limits.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vrased_cycle_timer.sv
// Loadable down-counter. expire_o flags the last counted cycle (count == 1).
module vrased_cycle_timer #(
    parameter int             W         = 6,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins over a decrement; the counter never wraps below zero.
    always_comb begin
        // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register, preloaded on reset so the controller starts its vector wait immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/violation_reset_ctrl.sv
// Turns any monitor violation into a fixed-length core reset pulse, then waits for the
// reset-vector fetch (retrying the pulse on timeout). Keeps a sticky cause mask and a
// saturating episode counter for diagnostics.
module violation_reset_ctrl
    import vrased_pkg::vr_state_e, vrased_pkg::RUN, vrased_pkg::HOLD, vrased_pkg::WAIT_VEC,
           vrased_pkg::max_int;
#(
    parameter logic [15:0] RESET_HANDLER = vrased_pkg::RESET_HANDLER,
    parameter int          NUM_SRC       = 4,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          VEC_TIMEOUT   = 32,
    parameter int          CNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] viol_i,
    input  logic [15:0]        pc,
    input  logic               clear_i,
    output logic               sys_rst_o,
    output logic               busy_o,
    output logic [NUM_SRC-1:0] cause_o,
    output logic [CNT_W-1:0]   viol_count_o
);

    localparam int TIMER_W = $clog2(max_int(HOLD_CYCLES, VEC_TIMEOUT)) + 1;
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES);
    localparam logic [TIMER_W-1:0] VEC_LOAD  = TIMER_W'(VEC_TIMEOUT);

    vr_state_e            state_q, state_d;
    logic                 sys_rst_q, sys_rst_d;
    logic                 busy_q, busy_d;
    logic [NUM_SRC-1:0]   cause_q, cause_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_dec;
    logic                 timer_expire;

    // Single timer shared by HOLD (pulse length) and WAIT_VEC (vector-fetch timeout).
    vrased_cycle_timer #(
        .W         (TIMER_W),
        .RESET_VAL (VEC_LOAD)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .dec_i      (timer_dec),
        .expire_o   (timer_expire)
    );

    // State register; reset lands in WAIT_VEC so monitors powering up in kill state are tolerated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_VEC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: violation starts a pulse, vector fetch ends the wait, timeout retries.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (|viol_i)                state_d = HOLD;
            HOLD:     if (timer_expire)           state_d = WAIT_VEC;
            WAIT_VEC: if (pc == RESET_HANDLER)    state_d = RUN;
                      else if (timer_expire)      state_d = HOLD;
            default:                              state_d = WAIT_VEC;
        endcase
    end

    // Output/datapath next values: timer control, registered flags, cause mask and counter.
    always_comb begin
        timer_load = (state_d != state_q) && (state_d != RUN);
        timer_val  = (state_d == HOLD) ? HOLD_LOAD : VEC_LOAD;
        timer_dec  = (state_q != RUN);
        sys_rst_d  = (state_d == HOLD);
        busy_d     = (state_d != RUN);
        cause_d    = cause_q;
        count_d    = count_q;
        unique case (state_q)
            RUN: begin
                if (|viol_i) begin
                    // A simultaneous clear is applied first, so the new episode starts a fresh record.
                    cause_d = (clear_i ? '0 : cause_q) | viol_i;
                    count_d = clear_i ? '0 : count_q;
                    if (!(&count_d)) begin
                        count_d = count_d + 1'b1;
                    end
                end else if (clear_i) begin
                    cause_d = '0;
                    count_d = '0;
                end
            end
            HOLD:     cause_d = cause_q | viol_i;
            default: ;
        endcase
    end

    // Output and diagnostic registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sys_rst_q <= 1'b0;
            busy_q    <= 1'b1;
            cause_q   <= '0;
            count_q   <= '0;
        end else begin
            sys_rst_q <= sys_rst_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
        end
    end

    assign sys_rst_o    = sys_rst_q;
    assign busy_o       = busy_q;
    assign cause_o      = cause_q;
    assign viol_count_o = count_q;

endmodule
